// File: rtl/rs_tdp36k_fifo_if.sv
// Handshake and data bundle for the 2048x18 FIFO: write/read requests,
// write data, registered read data and the 8-bit status word.
interface rs_tdp36k_fifo_if;
   logic        WEN_A1;
   logic [17:0] WDATA_A1;
   logic        REN_B1;
   logic [17:0] RDATA_B1;
   logic [7:0]  RDATA_A1;

   modport master (
      output WEN_A1,
      output WDATA_A1,
      output REN_B1,
      input  RDATA_B1,
      input  RDATA_A1
   );

   modport slave (
      input  WEN_A1,
      input  WDATA_A1,
      input  REN_B1,
      output RDATA_B1,
      output RDATA_A1
   );
endinterface

// File: rtl/rs_tdp36k_fifo.sv
// Single-clock 2048x18 FIFO with registered read data and a registered
// status word {EMPTY, ALMOST_EMPTY, PROG_EMPTY, UNDERFLOW, FULL, ALMOST_FULL, PROG_FULL, OVERFLOW}.
module rs_tdp36k_fifo #(
   parameter logic [10:0] PROG_EMPTY_THRESH = 11'd4,
   parameter logic [10:0] PROG_FULL_THRESH  = 11'd1274
) (
   input logic               CLK_A1,
   input logic               FLUSH1,
   rs_tdp36k_fifo_if.slave   fifo
);

   localparam logic [11:0] DEPTH = 12'd2048;

   logic [17:0] mem_q [0:2047];
   logic [10:0] wrPtr_q, wrPtr_d;
   logic [10:0] rdPtr_q, rdPtr_d;
   logic [11:0] count_q, count_d;
   logic [17:0] rdata_q;
   logic [7:0]  status_q, status_d;
   logic        wrAccept;
   logic        rdAccept;
   logic        emptyFlag;
   logic        fullFlag;

   assign emptyFlag = status_q[7];
   assign fullFlag  = status_q[3];

   // Acceptance looks only at the registered flags, so a read cannot make room
   // for a same-cycle write at FULL (and vice versa at EMPTY).
   always_comb begin
      wrAccept = fifo.WEN_A1 & ~fullFlag;
      rdAccept = fifo.REN_B1 & ~emptyFlag;
      wrPtr_d  = wrAccept ? wrPtr_q + 11'd1 : wrPtr_q;
      rdPtr_d  = rdAccept ? rdPtr_q + 11'd1 : rdPtr_q;
      count_d  = count_q;
      case ({wrAccept, rdAccept})
         2'b10:   count_d = count_q + 12'd1;
         2'b01:   count_d = count_q - 12'd1;
         default: count_d = count_q;
      endcase
      status_d = {
         count_d == 12'd0,
         count_d == 12'd1,
         count_d <= {1'b0, PROG_EMPTY_THRESH},
         fifo.REN_B1 & emptyFlag,
         count_d == DEPTH,
         count_d == DEPTH - 12'd1,
         count_d >= {1'b0, PROG_FULL_THRESH},
         fifo.WEN_A1 & fullFlag
      };
   end

   // Storage has no reset so it can map onto block RAM.
   always_ff @(posedge CLK_A1) begin
      if (wrAccept) begin
         mem_q[wrPtr_q] <= fifo.WDATA_A1;
      end
   end

   always_ff @(posedge CLK_A1 or negedge FLUSH1) begin
      if (!FLUSH1) begin
         wrPtr_q  <= 11'd0;
         rdPtr_q  <= 11'd0;
         count_q  <= 12'd0;
         rdata_q  <= 18'd0;
         status_q <= 8'hA0;
      end else begin
         wrPtr_q  <= wrPtr_d;
         rdPtr_q  <= rdPtr_d;
         count_q  <= count_d;
         status_q <= status_d;
         if (rdAccept) begin
            rdata_q <= mem_q[rdPtr_q];
         end
      end
   end

   assign fifo.RDATA_B1 = rdata_q;
   assign fifo.RDATA_A1 = status_q;

endmodule

// File: tb/tb_rs_tdp36k_fifo.sv
// Self-checking bench for rs_tdp36k_fifo: hand-derived vector table, corner
// sequences with constant expectations, and random traffic against a queue model.
module tb_rs_tdp36k_fifo;

   localparam logic [10:0] PE_THRESH = 11'd4;
   localparam logic [10:0] PF_THRESH = 11'd1274;

   logic CLK_A1;
   logic FLUSH1;

   rs_tdp36k_fifo_if fifoBus();

   rs_tdp36k_fifo #(
      .PROG_EMPTY_THRESH (PE_THRESH),
      .PROG_FULL_THRESH  (PF_THRESH)
   ) dut (
      .CLK_A1 (CLK_A1),
      .FLUSH1 (FLUSH1),
      .fifo   (fifoBus.slave)
   );

   initial CLK_A1 = 1'b0;
   always #5 CLK_A1 = ~CLK_A1;

   typedef struct packed {
      logic        wen;
      logic [17:0] wdata;
      logic        ren;
      logic [17:0] expRdata;
      logic [7:0]  expStatus;
   } vecT;

   vecT         vecs [17];
   logic [17:0] model [$];
   logic [17:0] expRdata;
   logic [7:0]  expStatus;
   int          vectorCount;
   int          missCount;

   // Status word derived straight from the occupancy and the two error events.
   function automatic logic [7:0] statusOf(input int n, input logic uf, input logic of);
      statusOf = {n == 0, n == 1, n <= int'(PE_THRESH), uf,
                  n == 2048, n == 2047, n >= int'(PF_THRESH), of};
   endfunction

   task automatic checkOutput(input string name, input logic [17:0] rd, input logic [7:0] st);
      vectorCount++;
      if (fifoBus.RDATA_B1 !== rd || fifoBus.RDATA_A1 !== st) begin
         missCount++;
         $display("[TB] FAIL %s: RDATA_B1=%h expected %h, RDATA_A1=%b expected %b",
                  name, fifoBus.RDATA_B1, rd, fifoBus.RDATA_A1, st);
      end
   endtask

   task automatic checkModel(input string name);
      checkOutput(name, expRdata, expStatus);
   endtask

   // Drive one cycle of requests and advance the queue model past the edge.
   task automatic applyStimulus(input logic wen, input logic [17:0] wdata, input logic ren);
      bit wasFull;
      bit wasEmpty;
      @(negedge CLK_A1);
      fifoBus.WEN_A1   = wen;
      fifoBus.WDATA_A1 = wdata;
      fifoBus.REN_B1   = ren;
      @(posedge CLK_A1);
      #1;
      wasFull  = (model.size() == 2048);
      wasEmpty = (model.size() == 0);
      if (ren && !wasEmpty) expRdata = model.pop_front();
      if (wen && !wasFull) model.push_back(wdata);
      expStatus = statusOf(model.size(), ren && wasEmpty, wen && wasFull);
   endtask

   // Pull FLUSH1 low between edges, check the immediate effect, release just after an edge.
   task automatic doReset(input string name);
      @(negedge CLK_A1);
      #2;
      FLUSH1 = 1'b0;
      fifoBus.WEN_A1 = 1'b0;
      fifoBus.REN_B1 = 1'b0;
      #1;
      checkOutput(name, 18'h0, 8'hA0);
      model.delete();
      expRdata  = 18'h0;
      expStatus = 8'hA0;
      @(posedge CLK_A1);
      #1;
      FLUSH1 = 1'b1;
   endtask

   task automatic randomPhase(input string name, input int cycles, input int wenPct, input int renPct);
      for (int i = 0; i < cycles; i++) begin
         applyStimulus($urandom_range(0, 99) < wenPct, 18'($urandom), $urandom_range(0, 99) < renPct);
         checkModel(name);
      end
   endtask

   initial begin
      vectorCount      = 0;
      missCount        = 0;
      FLUSH1           = 1'b0;
      fifoBus.WEN_A1   = 1'b0;
      fifoBus.WDATA_A1 = 18'h0;
      fifoBus.REN_B1   = 1'b0;
      expRdata         = 18'h0;
      expStatus        = 8'hA0;

      // {wen, wdata, ren, expected RDATA_B1, expected status}
      vecs[0]  = '{1'b0, 18'h00000, 1'b1, 18'h00000, 8'hB0};
      vecs[1]  = '{1'b1, 18'h00001, 1'b0, 18'h00000, 8'h60};
      vecs[2]  = '{1'b1, 18'h00002, 1'b0, 18'h00000, 8'h20};
      vecs[3]  = '{1'b1, 18'h00003, 1'b0, 18'h00000, 8'h20};
      vecs[4]  = '{1'b0, 18'h00000, 1'b1, 18'h00001, 8'h20};
      vecs[5]  = '{1'b0, 18'h00000, 1'b1, 18'h00002, 8'h60};
      vecs[6]  = '{1'b0, 18'h00000, 1'b1, 18'h00003, 8'hA0};
      vecs[7]  = '{1'b0, 18'h00000, 1'b0, 18'h00003, 8'hA0};
      vecs[8]  = '{1'b1, 18'h3FFFF, 1'b1, 18'h00003, 8'h70};
      vecs[9]  = '{1'b0, 18'h00000, 1'b1, 18'h3FFFF, 8'hA0};
      vecs[10] = '{1'b1, 18'h0000A, 1'b0, 18'h3FFFF, 8'h60};
      vecs[11] = '{1'b1, 18'h0000B, 1'b0, 18'h3FFFF, 8'h20};
      vecs[12] = '{1'b1, 18'h0000C, 1'b0, 18'h3FFFF, 8'h20};
      vecs[13] = '{1'b1, 18'h0000D, 1'b0, 18'h3FFFF, 8'h20};
      vecs[14] = '{1'b1, 18'h0000E, 1'b0, 18'h3FFFF, 8'h00};
      vecs[15] = '{1'b1, 18'h0000F, 1'b1, 18'h0000A, 8'h00};
      vecs[16] = '{1'b0, 18'h00000, 1'b1, 18'h0000B, 8'h20};

      repeat (3) @(posedge CLK_A1);
      #1;
      checkOutput("resetState", 18'h0, 8'hA0);
      FLUSH1 = 1'b1;

      for (int i = 0; i < 17; i++) begin
         applyStimulus(vecs[i].wen, vecs[i].wdata, vecs[i].ren);
         checkOutput($sformatf("vec%0d", i), vecs[i].expRdata, vecs[i].expStatus);
      end

      // Fill to full and beyond, then collide read and write at FULL.
      doReset("flushBeforeFill");
      for (int i = 0; i < 2048; i++) begin
         applyStimulus(1'b1, 18'(i), 1'b0);
         checkModel("fill");
      end
      checkOutput("fullFlags", 18'h0, 8'h0A);
      applyStimulus(1'b1, 18'h2AAAA, 1'b0);
      checkOutput("overflowPulse", 18'h0, 8'h0B);
      applyStimulus(1'b0, 18'h0, 1'b0);
      checkOutput("overflowClears", 18'h0, 8'h0A);
      applyStimulus(1'b1, 18'h15555, 1'b1);
      checkOutput("rwAtFull", 18'h00000, 8'h07);
      applyStimulus(1'b0, 18'h0, 1'b1);
      checkOutput("readAfterFull", 18'h00001, 8'h02);

      // Continuous interleaved traffic at low occupancy wraps both pointers.
      doReset("flushBeforeWrap");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 18'($urandom), 1'b0);
         checkModel("wrapPrime");
      end
      for (int i = 0; i < 4100; i++) begin
         applyStimulus(1'b1, 18'($urandom), 1'b1);
         checkModel("wrapStream");
      end

      doReset("flushBeforeRandom");
      randomPhase("randBalanced", 3000, 50, 50);
      randomPhase("randFilling", 2500, 75, 35);
      randomPhase("randDraining", 2500, 30, 70);

      // Asynchronous flush with ten words stored, then a read must underflow.
      doReset("flushBeforeAsync");
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 18'(i + 100), 1'b0);
         checkModel("asyncPrime");
      end
      applyStimulus(1'b0, 18'h0, 1'b1);
      checkOutput("asyncPrimeRead", 18'd100, 8'h00);
      applyStimulus(1'b1, 18'd110, 1'b0);
      checkOutput("count10", 18'd100, 8'h00);
      doReset("asyncFlushMidOp");
      applyStimulus(1'b0, 18'h0, 1'b1);
      checkOutput("underflowAfterFlush", 18'h0, 8'hB0);
      applyStimulus(1'b1, 18'h12345, 1'b0);
      applyStimulus(1'b0, 18'h0, 1'b1);
      checkOutput("noStaleData", 18'h12345, 8'hA0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
